// File: rtl/msrv32_pkg.sv
// Shared RV32 decode constants and the registered control bundle type.
package msrv32_pkg;

    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_PRIV    = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_LOAD  = 3'b001;
    localparam logic [2:0] WB_LUI   = 3'b010;
    localparam logic [2:0] WB_AUIPC = 3'b011;
    localparam logic [2:0] WB_CSR   = 3'b100;
    localparam logic [2:0] WB_PC4   = 3'b101;

    localparam logic [2:0] IMM_R   = 3'b000;
    localparam logic [2:0] IMM_I   = 3'b001;
    localparam logic [2:0] IMM_S   = 3'b010;
    localparam logic [2:0] IMM_B   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_J   = 3'b101;
    localparam logic [2:0] IMM_CSR = 3'b110;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [3:0] alu_opcode;
        logic       is_muldiv;
        logic [2:0] muldiv_op;
        logic       mem_wr_req;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic       alu_src;
        logic       iadder_src;
        logic       csr_wr_en;
        logic [2:0] csr_op;
        logic       rf_wr_en;
        logic [2:0] wb_mux_sel;
        logic [2:0] imm_type;
        logic       illegal;
        logic       misaligned_load;
        logic       misaligned_store;
    } dec_bundle_t;

endpackage

// File: rtl/msrv32_dec_core.sv
// Purely combinational RV32(I/M) decode of one instruction word into the control bundle.
module msrv32_dec_core
    import msrv32_pkg::*;
#(
    parameter int ENABLE_M      = 1,
    parameter int STRICT_FUNCT7 = 1
) (
    input  logic [31:0] instr,
    input  logic [1:0]  iadder,
    output dec_bundle_t bundle
);

    logic [4:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_misc_mem, is_system, is_csr, known_class;
    logic is_shift_imm, op_f7_ok, shift_f7_ok, muldiv, illegal;
    logic mis_access;

    assign opc    = instr[6:2];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign is_op       = (opc == OPC_OP);
    assign is_op_imm   = (opc == OPC_OP_IMM);
    assign is_load     = (opc == OPC_LOAD);
    assign is_store    = (opc == OPC_STORE);
    assign is_branch   = (opc == OPC_BRANCH);
    assign is_jal      = (opc == OPC_JAL);
    assign is_jalr     = (opc == OPC_JALR);
    assign is_lui      = (opc == OPC_LUI);
    assign is_auipc    = (opc == OPC_AUIPC);
    assign is_misc_mem = (opc == OPC_MISC_MEM);
    assign is_system   = (opc == OPC_SYSTEM);
    assign is_csr      = is_system & (funct3 != F3_PRIV);

    assign known_class = is_op | is_op_imm | is_load | is_store | is_branch | is_jal
                       | is_jalr | is_lui | is_auipc | is_misc_mem | is_system;

    assign is_shift_imm = is_op_imm & ((funct3 == F3_SLL) | (funct3 == F3_SRL_SRA));

    // funct7=0000001 on OP is only ever legal as an M-extension op, strict or not.
    always_comb begin
        op_f7_ok = 1'b0;
        if (funct7 == F7_MULDIV)       op_f7_ok = (ENABLE_M != 0);
        else if (STRICT_FUNCT7 == 0)   op_f7_ok = 1'b1;
        else if (funct7 == F7_BASE)    op_f7_ok = 1'b1;
        else if (funct7 == F7_ALT)     op_f7_ok = (funct3 == F3_ADD_SUB) | (funct3 == F3_SRL_SRA);
    end

    always_comb begin
        shift_f7_ok = 1'b0;
        if (STRICT_FUNCT7 == 0)        shift_f7_ok = 1'b1;
        else if (funct7 == F7_BASE)    shift_f7_ok = 1'b1;
        else if (funct7 == F7_ALT)     shift_f7_ok = (funct3 == F3_SRL_SRA);
    end

    assign muldiv  = (ENABLE_M != 0) & is_op & (funct7 == F7_MULDIV);
    assign illegal = (instr[1:0] != 2'b11) | ~known_class
                   | (is_op & ~op_f7_ok) | (is_shift_imm & ~shift_f7_ok);

    assign mis_access = ((funct3[1:0] == SIZE_WORD) & (iadder != 2'b00))
                      | ((funct3[1:0] == SIZE_HALF) & iadder[0]);

    always_comb begin
        bundle                  = '0;
        bundle.rd_addr          = instr[11:7];
        bundle.rs1_addr         = instr[19:15];
        bundle.rs2_addr         = instr[24:20];
        bundle.alu_opcode[2:0]  = funct3;
        bundle.alu_opcode[3]    = instr[30] & ~muldiv
                                & (is_op | (is_op_imm & (funct3 == F3_SRL_SRA)));
        bundle.is_muldiv        = muldiv;
        bundle.muldiv_op        = muldiv ? funct3 : 3'b000;
        bundle.misaligned_load  = is_load & mis_access;
        bundle.misaligned_store = is_store & mis_access;
        bundle.mem_wr_req       = is_store & ~bundle.misaligned_store & ~illegal;
        bundle.load_size        = funct3[1:0];
        bundle.load_unsigned    = funct3[2];
        bundle.alu_src          = instr[5];
        bundle.iadder_src       = is_load | is_store | is_jalr;
        bundle.csr_wr_en        = is_csr & ~illegal;
        bundle.csr_op           = funct3;
        bundle.rf_wr_en         = ~illegal & (is_lui | is_auipc | is_jal | is_jalr | is_op
                                              | is_op_imm | is_load | is_csr);
        bundle.illegal          = illegal;

        // Classes are mutually exclusive, so the first match is the only match.
        if (is_load)                 bundle.wb_mux_sel = WB_LOAD;
        else if (is_lui)             bundle.wb_mux_sel = WB_LUI;
        else if (is_auipc)           bundle.wb_mux_sel = WB_AUIPC;
        else if (is_jal | is_jalr)   bundle.wb_mux_sel = WB_PC4;
        else if (is_csr)             bundle.wb_mux_sel = WB_CSR;
        else                         bundle.wb_mux_sel = WB_ALU;

        if (is_op_imm | is_load | is_jalr) bundle.imm_type = IMM_I;
        else if (is_store)                 bundle.imm_type = IMM_S;
        else if (is_branch)                bundle.imm_type = IMM_B;
        else if (is_lui | is_auipc)        bundle.imm_type = IMM_U;
        else if (is_jal)                   bundle.imm_type = IMM_J;
        else if (is_csr)                   bundle.imm_type = IMM_CSR;
        else                               bundle.imm_type = IMM_R;
    end

endmodule

// File: rtl/msrv32_dec_stage.sv
// Registered decode stage: valid/ready pipeline register around msrv32_dec_core plus illegal counter.
module msrv32_dec_stage
    import msrv32_pkg::*;
#(
    parameter int ENABLE_M      = 1,
    parameter int STRICT_FUNCT7 = 1,
    parameter int CNT_W         = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [1:0]       iadder_1_to_0_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [4:0]       rd_addr_out,
    output logic [4:0]       rs1_addr_out,
    output logic [4:0]       rs2_addr_out,
    output logic [3:0]       alu_opcode_out,
    output logic             is_muldiv_out,
    output logic [2:0]       muldiv_op_out,
    output logic             mem_wr_req_out,
    output logic [1:0]       load_size_out,
    output logic             load_unsigned_out,
    output logic             alu_src_out,
    output logic             iadder_src_out,
    output logic             csr_wr_en_out,
    output logic [2:0]       csr_op_out,
    output logic             rf_wr_en_out,
    output logic [2:0]       wb_mux_sel_out,
    output logic [2:0]       imm_type_out,
    output logic             illegal_instr_out,
    output logic             misaligned_load_out,
    output logic             misaligned_store_out,
    output logic [CNT_W-1:0] illegal_cnt_out
);

    dec_bundle_t      dec_bundle, bundle_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] illegal_cnt_q;
    logic             load, retire, retire_illegal;

    msrv32_dec_core #(
        .ENABLE_M      (ENABLE_M),
        .STRICT_FUNCT7 (STRICT_FUNCT7)
    ) u_core (
        .instr  (instr_in),
        .iadder (iadder_1_to_0_in),
        .bundle (dec_bundle)
    );

    // Handshake: a beat transfers on an edge where valid & ready are both high; the
    // producer keeps valid and data stable until then, and flush_in overrides both sides.
    assign in_ready_out   = ~out_valid_q | out_ready_in;
    assign load           = in_valid_in & in_ready_out & ~flush_in;
    assign retire         = out_valid_q & out_ready_in & ~flush_in;
    assign retire_illegal = retire & bundle_q.illegal;

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            out_valid_q   <= 1'b0;
            bundle_q      <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (flush_in) begin
                out_valid_q <= 1'b0;
            end else if (load) begin
                bundle_q    <= dec_bundle;
                out_valid_q <= 1'b1;
            end else if (out_valid_q & out_ready_in) begin
                out_valid_q <= 1'b0;
            end

            if (retire_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
                illegal_cnt_q <= illegal_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid_out        = out_valid_q;
    assign rd_addr_out          = bundle_q.rd_addr;
    assign rs1_addr_out         = bundle_q.rs1_addr;
    assign rs2_addr_out         = bundle_q.rs2_addr;
    assign alu_opcode_out       = bundle_q.alu_opcode;
    assign is_muldiv_out        = bundle_q.is_muldiv;
    assign muldiv_op_out        = bundle_q.muldiv_op;
    // A trap must cancel a store in the same cycle it is raised.
    assign mem_wr_req_out       = bundle_q.mem_wr_req & out_valid_q & ~flush_in;
    assign load_size_out        = bundle_q.load_size;
    assign load_unsigned_out    = bundle_q.load_unsigned;
    assign alu_src_out          = bundle_q.alu_src;
    assign iadder_src_out       = bundle_q.iadder_src;
    assign csr_wr_en_out        = bundle_q.csr_wr_en;
    assign csr_op_out           = bundle_q.csr_op;
    assign rf_wr_en_out         = bundle_q.rf_wr_en;
    assign wb_mux_sel_out       = bundle_q.wb_mux_sel;
    assign imm_type_out         = bundle_q.imm_type;
    assign illegal_instr_out    = bundle_q.illegal;
    assign misaligned_load_out  = bundle_q.misaligned_load;
    assign misaligned_store_out = bundle_q.misaligned_store;
    assign illegal_cnt_out      = illegal_cnt_q;

endmodule

// File: tb/tb_msrv32_dec_stage.sv
// Directed bench for msrv32_dec_stage: default instance plus an ENABLE_M=0, CNT_W=2 instance.
module tb_msrv32_dec_stage;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_SW  = 32'h0020A023;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [1:0]  iadder;

  logic        a_in_ready, a_out_valid, a_is_muldiv, a_mem_wr, a_load_uns, a_alu_src, a_iadder_src;
  logic        a_csr_wr, a_rf_wr, a_illegal, a_mis_ld, a_mis_st;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [3:0]  a_alu;
  logic [2:0]  a_mdop, a_csr_op, a_wb, a_imm;
  logic [1:0]  a_ld_size;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_is_muldiv, b_mem_wr, b_load_uns, b_alu_src, b_iadder_src;
  logic        b_csr_wr, b_rf_wr, b_illegal, b_mis_ld, b_mis_st;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [3:0]  b_alu;
  logic [2:0]  b_mdop, b_csr_op, b_wb, b_imm;
  logic [1:0]  b_ld_size;
  logic [1:0]  b_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  msrv32_dec_stage dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush),
    .in_valid_in(in_valid), .in_ready_out(a_in_ready), .instr_in(instr),
    .iadder_1_to_0_in(iadder), .out_valid_out(a_out_valid), .out_ready_in(out_ready),
    .rd_addr_out(a_rd), .rs1_addr_out(a_rs1), .rs2_addr_out(a_rs2), .alu_opcode_out(a_alu),
    .is_muldiv_out(a_is_muldiv), .muldiv_op_out(a_mdop), .mem_wr_req_out(a_mem_wr),
    .load_size_out(a_ld_size), .load_unsigned_out(a_load_uns), .alu_src_out(a_alu_src),
    .iadder_src_out(a_iadder_src), .csr_wr_en_out(a_csr_wr), .csr_op_out(a_csr_op),
    .rf_wr_en_out(a_rf_wr), .wb_mux_sel_out(a_wb), .imm_type_out(a_imm),
    .illegal_instr_out(a_illegal), .misaligned_load_out(a_mis_ld),
    .misaligned_store_out(a_mis_st), .illegal_cnt_out(a_cnt)
  );

  msrv32_dec_stage #(.ENABLE_M(0), .STRICT_FUNCT7(1), .CNT_W(2)) dut_b (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush),
    .in_valid_in(in_valid), .in_ready_out(b_in_ready), .instr_in(instr),
    .iadder_1_to_0_in(iadder), .out_valid_out(b_out_valid), .out_ready_in(out_ready),
    .rd_addr_out(b_rd), .rs1_addr_out(b_rs1), .rs2_addr_out(b_rs2), .alu_opcode_out(b_alu),
    .is_muldiv_out(b_is_muldiv), .muldiv_op_out(b_mdop), .mem_wr_req_out(b_mem_wr),
    .load_size_out(b_ld_size), .load_unsigned_out(b_load_uns), .alu_src_out(b_alu_src),
    .iadder_src_out(b_iadder_src), .csr_wr_en_out(b_csr_wr), .csr_op_out(b_csr_op),
    .rf_wr_en_out(b_rf_wr), .wb_mux_sel_out(b_wb), .imm_type_out(b_imm),
    .illegal_instr_out(b_illegal), .misaligned_load_out(b_mis_ld),
    .misaligned_store_out(b_mis_st), .illegal_cnt_out(b_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver: advance one cycle and sample 1 ns after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [1:0] ia);
    in_valid = v;
    instr    = w;
    iadder   = ia;
  endtask

  initial begin
    logic [1:0] cnt_seq [5];
    logic [3:0] exp_alu;
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'b00);
    #3;
    check("reset_valid", a_out_valid, 0);
    check("reset_in_ready", a_in_ready, 1);
    check("reset_cnt", a_cnt, 0);
    tick(); tick();
    rst = 1'b0;

    // reset asserted mid-stall
    drive(1'b1, I_ADD, 2'b00);
    tick();
    check("stall_load_valid", a_out_valid, 1);
    check("stall_load_rd", a_rd, 3);
    drive(1'b0, 32'h0, 2'b00);
    tick();
    check("stall_hold_valid", a_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", a_out_valid, 0);
    check("async_rst_rd", a_rd, 0);
    check("async_rst_rs1", a_rs1, 0);
    check("async_rst_rf_wr", a_rf_wr, 0);
    check("async_rst_cnt", a_cnt, 0);
    tick();
    rst = 1'b0;

    // back-to-back ADD, SUB, MUL
    out_ready = 1'b1;
    drive(1'b1, I_ADD, 2'b00); exp_q.push_back(4'b0000);
    tick();
    exp_alu = exp_q.pop_front();
    check("add_valid", a_out_valid, 1);
    check("add_alu", a_alu, exp_alu);
    check("add_regs", {a_rd, a_rs1, a_rs2}, {5'd3, 5'd1, 5'd2});
    check("add_rf_wr", a_rf_wr, 1);
    check("add_wb_imm", {a_wb, a_imm}, 6'b000000);
    drive(1'b1, I_SUB, 2'b00); exp_q.push_back(4'b1000);
    tick();
    exp_alu = exp_q.pop_front();
    check("sub_valid", a_out_valid, 1);
    check("sub_alu", a_alu, exp_alu);
    check("sub_illegal", a_illegal, 0);
    drive(1'b1, I_MUL, 2'b00); exp_q.push_back(4'b0000);
    tick();
    exp_alu = exp_q.pop_front();
    check("mul_valid", a_out_valid, 1);
    check("mul_alu", a_alu, exp_alu);
    check("mul_is_muldiv", a_is_muldiv, 1);
    check("mul_op", a_mdop, 0);
    check("mul_illegal", a_illegal, 0);
    check("mul_rf_wr", a_rf_wr, 1);
    check("mul_nom_illegal", b_illegal, 1);
    check("mul_nom_rf_wr", b_rf_wr, 0);
    check("mul_nom_muldiv", b_is_muldiv, 0);
    drive(1'b0, 32'h0, 2'b00);
    tick();
    check("drain_valid", a_out_valid, 0);

    // store alignment
    drive(1'b1, I_SW, 2'b10);
    tick();
    check("sw_mis_store", a_mis_st, 1);
    check("sw_mis_wr", a_mem_wr, 0);
    check("sw_mis_ld", a_mis_ld, 0);
    drive(1'b1, I_SW, 2'b00);
    tick();
    check("sw_ok_wr", a_mem_wr, 1);
    check("sw_ok_imm", a_imm, 3'b010);
    check("sw_ok_mis", a_mis_st, 0);
    check("sw_ok_rf_wr", a_rf_wr, 0);
    check("sw_ok_iadder_src", a_iadder_src, 1);
    check("sw_ok_size", a_ld_size, 2'b10);

    // backpressure with a new instruction waiting
    out_ready = 1'b0;
    drive(1'b1, I_ADD, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", a_in_ready, 0);
      check("bp_valid", a_out_valid, 1);
      check("bp_rd_hold", a_rd, 0);
      check("bp_wr_hold", a_mem_wr, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", a_in_ready, 1);
    tick();
    check("bp_next_valid", a_out_valid, 1);
    check("bp_next_rd", a_rd, 3);
    check("bp_next_wr", a_mem_wr, 0);
    drive(1'b0, 32'h0, 2'b00);
    tick();
    check("bp_drain", a_out_valid, 0);

    // flush with a held store and an incoming instruction
    out_ready = 1'b0;
    drive(1'b1, I_SW, 2'b00);
    tick();
    check("fl_held_wr", a_mem_wr, 1);
    drive(1'b1, I_ADD, 2'b00);
    flush = 1'b1;
    #1;
    check("fl_wr_gated", a_mem_wr, 0);
    tick();
    check("fl_valid", a_out_valid, 0);
    check("fl_dropped_rd", a_rd, 0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 2'b00);
    tick();
    check("fl_still_empty", a_out_valid, 0);
    out_ready = 1'b1;

    // saturating counter on the CNT_W=2 instance
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    check("cnt_reset", b_cnt, 0);
    drive(1'b1, 32'h0000_0000, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("cnt_illegal", b_illegal, 1);
      check("cnt_rf_wr", b_rf_wr, 0);
      check("cnt_value", b_cnt, (k == 0) ? 2'd0 : cnt_seq[k-1]);
    end
    drive(1'b0, 32'h0, 2'b00);
    tick();
    check("cnt_final", b_cnt, cnt_seq[4]);
    check("cnt_wide", a_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msrv32_dec_stage.md
Name: msrv32_dec_stage

Overview:
- Registered, parametrised successor to the combinational RV32 decoder.
- Accepts a fetched 32-bit instruction plus the two low bits of the integer-adder result over a valid/ready handshake, decodes it, and holds the control bundle in a pipeline register.
- Optionally decodes the RV32M extension, tightens illegal-instruction detection, and counts retired illegal instructions.
- Sits between fetch and register-file/execute; flushed by a trap.

Parameters:
- ENABLE_M, 1: 1 = decode MUL/DIV (OP opcode, funct7=0000001); 0 = such encodings are illegal.
- STRICT_FUNCT7, 1: 1 = OP, and OP-IMM shifts, require funct7 in {0000000, 0100000}; 0100000 is allowed only with funct3 000 (OP only) or 101.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset
- flush_in  in  1  trap taken; kills the held and incoming instruction
- in_valid_in  in  1  instruction valid
- in_ready_out  out  1  stage can accept
- instr_in  in  32  instruction word
- iadder_1_to_0_in  in  2  low bits of the effective address
- out_valid_out  out  1  decoded bundle valid
- out_ready_in  in  1  downstream accepts
- rd_addr_out / rs1_addr_out / rs2_addr_out  out  5 each  instr[11:7] / [19:15] / [24:20]
- alu_opcode_out  out  4  {alt, funct3}
- is_muldiv_out  out  1  RV32M operation
- muldiv_op_out  out  3  funct3 when is_muldiv, else 0
- mem_wr_req_out  out  1  store request
- load_size_out  out  2  funct3[1:0]
- load_unsigned_out  out  1  funct3[2]
- alu_src_out  out  1  opcode[5]
- iadder_src_out  out  1  load | store | jalr
- csr_wr_en_out  out  1  SYSTEM with funct3≠000
- csr_op_out  out  3  funct3
- rf_wr_en_out  out  1  register-file write
- wb_mux_sel_out  out  3  writeback select
- imm_type_out  out  3  immediate format
- illegal_instr_out  out  1  illegal encoding
- misaligned_load_out / misaligned_store_out  out  1 each
- illegal_cnt_out  out  CNT_W  retired illegal count

Behaviour:
- Reset (asynchronous, takes effect immediately): all registered outputs 0, out_valid_out=0, counter=0.
- in_ready_out = ~out_valid_out | out_ready_in (combinational).
- Load condition: in_valid_in & in_ready_out & ~flush_in. On load, the bundle is captured and out_valid=1.
- Drain without load: if out_valid & out_ready_in and there is no load, out_valid=0.
- Flush: flush_in has priority over everything. Next edge out_valid=0 and nothing is loaded.
- Latency: exactly 1 cycle from load to out_valid. Back-to-back throughput is 1 per cycle while out_ready_in=1.
- Stall: while out_valid & ~out_ready_in, every output holds stable.
- Opcode class is instr[6:2]:
  - OP=01100, OP_IMM=00100, LOAD=00000, STORE=01000, BRANCH=11000
  - JAL=11011, JALR=11001, LUI=01101, AUIPC=00101, MISC_MEM=00011, SYSTEM=11100
- alu_opcode[2:0] = funct3.
- alu_opcode[3] = instr[30] for OP, and for OP_IMM with funct3=101; otherwise 0. It is forced to 0 when is_muldiv.
- is_muldiv = ENABLE_M & OP & funct7==0000001.
- rf_wr_en = lui | auipc | jal | jalr | op | op_imm | load | csr.
- wb_mux_sel:
  - [0] = load | auipc | jal | jalr
  - [1] = lui | auipc
  - [2] = csr | jal | jalr
- imm_type:
  - [0] = op_imm | load | jalr | branch | jal
  - [1] = store | branch | csr
  - [2] = lui | auipc | jal | csr
- illegal = instr[1:0]≠11, or unknown class, or a funct7 violation (per STRICT_FUNCT7 / ENABLE_M).
- When illegal: rf_wr_en, csr_wr_en and mem_wr_req are registered as 0.
- Misalignment, applied to load and store only:
  - word (funct3[1:0]=10) with any iadder bit set;
  - half (funct3[1:0]=01) with iadder[0] set.
- mem_wr_req_out = registered (store & ~misaligned & ~illegal) & out_valid_out & ~flush_in. This is the only combinational gate on an output.
- Counter: increments when out_valid & out_ready_in & illegal_instr_out & ~flush_in. It saturates at 2^CNT_W-1 and is never cleared except by reset.

Decomposition:
- Shared package msrv32_pkg holds:
  - opcode-class constants;
  - funct3 constants;
  - funct7 constants (0000000, 0100000, 0000001);
  - wb_mux_sel and imm_type encodings.
- One natural sub-module: msrv32_dec_core, purely combinational decode of instr plus iadder into the bundle. The stage wraps it with the handshake register and counter.

Test Plan:
- Reset mid-stall, with out_valid=1 and out_ready_in=0 → out_valid_out=0 and all outputs 0 immediately; counter=0.
- ADD 0x002081B3, then SUB 0x402081B3, then MUL 0x022081B3, back-to-back with out_ready_in=1:
  - ADD → alu_opcode 0000; SUB → 1000;
  - MUL with ENABLE_M=1 → is_muldiv=1, muldiv_op=000, alu_opcode=0000;
  - MUL with ENABLE_M=0 → illegal=1, rf_wr_en=0.
  - Each bundle appears exactly 1 cycle after its acceptance.
- SW 0x0020A023:
  - iadder=10 → misaligned_store=1, mem_wr_req=0;
  - iadder=00 → mem_wr_req=1, imm_type=010.
- Backpressure: hold out_ready_in=0 for 3 cycles with a new instr on the input → in_ready_out=0 and outputs unchanged; release → the next instr is visible one cycle later.
- Flush: assert flush_in with a valid SW held and in_valid_in=1 → mem_wr_req_out=0 the same cycle; out_valid_out=0 next cycle; the incoming instr is dropped.
- CNT_W=2, five retired words 0x00000000 → illegal_instr_out=1 each time; counter sequence 1,2,3,3,3.
